// File: rtl/match_pkg.sv
// Shared types and constants for the match result arbiter: FSM states,
// lane index width and result byte field layout.
package match_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_LANES_DEF   = 8;
    localparam int POS_W_DEF       = 5;
    localparam int MAX_RESULTS_DEF = 8;
    localparam int LANE_IDX_W      = 3;
    localparam int TDATA_W         = 8;
    localparam int TDATA_LANE_LSB  = 0;
    localparam int TDATA_POS_LSB   = LANE_IDX_W;

endpackage

// File: rtl/match_result_arbiter_if.sv
// Stream, lane-match and result-port signals of the match result arbiter.
// master = search engine / result consumer side, slave = arbiter.
interface match_result_arbiter_if
    import match_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF
);
    logic                 s_axis_tvalid;
    logic                 s_axis_tuser;
    logic [NUM_LANES-1:0] lane_match;
    logic [NUM_LANES-1:0] result_mask;
    logic                 m_axis_tvalid;
    logic [TDATA_W-1:0]   m_axis_tdata;
    logic                 m_axis_tready;
    logic [3:0]           result_count;
    logic                 overflow;
    logic                 done;

    modport master (
        output s_axis_tvalid, s_axis_tuser, lane_match, result_mask, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, result_count, overflow, done
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tuser, lane_match, result_mask, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, result_count, overflow, done
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pending strictly after
// rr_ptr, wrapping back around to rr_ptr itself last.
module rr_pick
    import match_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF
) (
    input  logic [NUM_LANES-1:0]  pending,
    input  logic [LANE_IDX_W-1:0] rr_ptr,
    output logic                  grant_valid,
    output logic [LANE_IDX_W-1:0] grant_idx
);
    logic [LANE_IDX_W-1:0] cand;

    // Scan farthest-first so the nearest pending lane after rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            cand = rr_ptr + LANE_IDX_W'(k);
            if (pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/match_result_arbiter.sv
// Serialises per-lane match events into a tagged 8-bit result stream with a
// per-frame result limit and a frame-drained pulse after the end marker.
module match_result_arbiter
    import match_pkg::*;
#(
    parameter int NUM_LANES   = NUM_LANES_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int MAX_RESULTS = MAX_RESULTS_DEF
) (
    input logic                    sclk,
    input logic                    rst_n,
    input logic                    aresetn,
    match_result_arbiter_if.slave  bus
);
    state_t                state_q, state_d;
    logic [NUM_LANES-1:0]  pending;
    logic [POS_W-1:0]      pos;
    logic [POS_W-1:0]      pos_q [NUM_LANES];
    logic [LANE_IDX_W-1:0] rr_ptr;
    logic [LANE_IDX_W-1:0] grant_idx;
    logic                  grant_valid;
    logic                  tvalid_q;
    logic [TDATA_W-1:0]    tdata_q;
    logic [3:0]            count_q;
    logic                  overflow_q;

    logic                  clear;
    logic                  capture_en;
    logic                  load_ok;
    logic                  take;
    logic                  under_limit;
    logic                  end_marker;
    logic [NUM_LANES-1:0]  hit;
    logic [NUM_LANES-1:0]  grant_vec;
    logic [NUM_LANES-1:0]  arm;
    logic                  drop;

    assign clear       = !rst_n || !aresetn;
    assign capture_en  = (state_q == RUN);
    assign end_marker  = bus.s_axis_tvalid && bus.s_axis_tuser;
    assign load_ok     = !tvalid_q || bus.m_axis_tready;
    assign take        = load_ok && grant_valid;
    assign under_limit = count_q < 4'(MAX_RESULTS);
    assign hit         = bus.lane_match & bus.result_mask & {NUM_LANES{capture_en}};
    assign grant_vec   = {{(NUM_LANES-1){1'b0}}, take} << grant_idx;
    // A lane freed by this cycle's grant may take the new match without loss.
    assign arm         = hit & (~pending | grant_vec);
    assign drop        = |(hit & pending & ~grant_vec);

    rr_pick #(.NUM_LANES(NUM_LANES)) u_rr_pick (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge sclk) begin
        if (clear) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.done = 1'b0;
        unique case (state_q)
            RUN:     if (end_marker) state_d = DRAIN;
            DRAIN:   if (pending == '0 && load_ok) state_d = DONE;
            DONE: begin
                bus.done = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Capture stage: per-lane position tags, written only when a lane is armed.
    always_ff @(posedge sclk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (arm[i]) pos_q[i] <= pos;
        end
    end

    // Output stage: single result register fed by the round-robin grant.
    always_ff @(posedge sclk) begin
        if (clear) begin
            pending    <= '0;
            pos        <= '0;
            rr_ptr     <= LANE_IDX_W'(NUM_LANES - 1);
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending <= (pending & ~grant_vec) | hit;
            if (take) rr_ptr <= grant_idx;

            if (state_q == DONE) begin
                pos <= '0;
            end else if (bus.s_axis_tvalid && !bus.s_axis_tuser && pos != '1) begin
                pos <= pos + POS_W'(1);
            end

            if (load_ok) tvalid_q <= take && under_limit;
            if (take && under_limit) begin
                tdata_q <= TDATA_W'({pos_q[grant_idx], grant_idx});
            end

            if (state_q == DONE) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (take && under_limit) count_q <= count_q + 4'd1;
                if (drop || (take && !under_limit)) overflow_q <= 1'b1;
            end
        end
    end

    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.result_count  = count_q;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_match_result_arbiter.sv
// Directed bench for match_result_arbiter: hand-computed result bytes,
// counters and flags checked one cycle step at a time.
module tb_match_result_arbiter;
  logic sclk = 1'b0;
  logic rst_n;
  logic aresetn;
  int   n_assert = 0;
  int   n_fail   = 0;

  match_result_arbiter_if #(.NUM_LANES(8)) bus ();

  match_result_arbiter dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic soft_clear();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    aresetn = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.lane_match    = 8'h00;
    bus.result_mask   = 8'hFF;
    bus.m_axis_tready = 1'b1;
    repeat (2) tick();
    chk("rst_tvalid", bus.m_axis_tvalid === 1'b0);
    chk("rst_tdata", bus.m_axis_tdata === 8'h00);
    chk("rst_count", bus.result_count === 4'd0);
    chk("rst_overflow", bus.overflow === 1'b0);
    chk("rst_done", bus.done === 1'b0);
    rst_n = 1'b1;

    // Single match: lane 2 at pos 5 -> 0x2A two cycles after the pulse
    bus.s_axis_tvalid = 1'b1;
    repeat (5) tick();
    bus.s_axis_tvalid = 1'b0;
    bus.lane_match = 8'h04;
    tick();
    bus.lane_match = 8'h00;
    chk("single_latency", bus.m_axis_tvalid === 1'b0);
    tick();
    chk("single_tvalid", bus.m_axis_tvalid === 1'b1);
    chk("single_tdata", bus.m_axis_tdata === 8'h2A);
    chk("single_count", bus.result_count === 4'd1);
    tick();
    chk("single_end", bus.m_axis_tvalid === 1'b0);

    // Simultaneous lanes 0,3,7 at pos 3 from rr_ptr=7
    soft_clear();
    chk("clr_count", bus.result_count === 4'd0);
    bus.s_axis_tvalid = 1'b1;
    repeat (3) tick();
    bus.s_axis_tvalid = 1'b0;
    bus.lane_match = 8'h89;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("multi_beat0", bus.m_axis_tdata === 8'h18);
    tick();
    chk("multi_beat3", bus.m_axis_tdata === 8'h1B);
    tick();
    chk("multi_beat7", bus.m_axis_tdata === 8'h1F);
    chk("multi_count", bus.result_count === 4'd3);
    tick();
    chk("multi_end", bus.m_axis_tvalid === 1'b0);

    // Backpressure, then lane 1 matching twice while pending
    soft_clear();
    bus.s_axis_tvalid = 1'b1;
    repeat (2) tick();
    bus.lane_match = 8'h02;
    bus.m_axis_tready = 1'b0;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("bp_tvalid", bus.m_axis_tvalid === 1'b1);
    chk("bp_tdata1", bus.m_axis_tdata === 8'h11);
    bus.lane_match = 8'h02;
    tick();
    chk("bp_tdata2", bus.m_axis_tdata === 8'h11);
    bus.s_axis_tvalid = 1'b0;
    tick();
    bus.lane_match = 8'h00;
    chk("bp_overflow", bus.overflow === 1'b1);
    chk("bp_tdata3", bus.m_axis_tdata === 8'h11);
    tick();
    chk("bp_tdata4", bus.m_axis_tdata === 8'h11);
    chk("bp_hold_valid", bus.m_axis_tvalid === 1'b1);
    chk("bp_count1", bus.result_count === 4'd1);
    bus.m_axis_tready = 1'b1;
    tick();
    chk("bp_second", bus.m_axis_tdata === 8'h21);
    chk("bp_count2", bus.result_count === 4'd2);
    tick();
    chk("bp_end", bus.m_axis_tvalid === 1'b0);
    chk("bp_sticky", bus.overflow === 1'b1);

    // Position saturates at 31
    soft_clear();
    bus.s_axis_tvalid = 1'b1;
    repeat (40) tick();
    bus.s_axis_tvalid = 1'b0;
    bus.lane_match = 8'h08;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("sat_tdata", bus.m_axis_tdata === 8'hFB);
    tick();

    // Result limit: 8 + 2 matches in one frame
    soft_clear();
    bus.s_axis_tvalid = 1'b1;
    tick();
    bus.s_axis_tvalid = 1'b0;
    bus.lane_match = 8'hFF;
    tick();
    bus.lane_match = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lim_valid", bus.m_axis_tvalid === 1'b1);
      chk("lim_tdata", bus.m_axis_tdata === 8'(8'h08 + i));
    end
    chk("lim_count8", bus.result_count === 4'd8);
    chk("lim_no_ovf_yet", bus.overflow === 1'b0);
    bus.lane_match = 8'h03;
    tick();
    bus.lane_match = 8'h00;
    chk("lim_idle", bus.m_axis_tvalid === 1'b0);
    tick();
    chk("lim_discard_valid", bus.m_axis_tvalid === 1'b0);
    chk("lim_overflow", bus.overflow === 1'b1);
    chk("lim_count_hold", bus.result_count === 4'd8);
    tick();
    chk("lim_discard2", bus.m_axis_tvalid === 1'b0);

    // End of frame with drops, ignored marker and match in DRAIN
    soft_clear();
    bus.s_axis_tvalid = 1'b1;
    repeat (3) tick();
    bus.lane_match = 8'h14;
    tick();
    bus.lane_match = 8'h12;
    bus.s_axis_tuser = 1'b1;
    tick();
    chk("eof_beat2", bus.m_axis_tdata === 8'h1A);
    chk("eof_overflow", bus.overflow === 1'b1);
    chk("eof_done0", bus.done === 1'b0);
    bus.lane_match = 8'h40;
    tick();
    chk("eof_beat4", bus.m_axis_tdata === 8'h1C);
    chk("eof_done1", bus.done === 1'b0);
    bus.lane_match = 8'h00;
    bus.s_axis_tuser = 1'b0;
    tick();
    chk("eof_beat1", bus.m_axis_tdata === 8'h21);
    chk("eof_count3", bus.result_count === 4'd3);
    chk("eof_done2", bus.done === 1'b0);
    bus.s_axis_tvalid = 1'b0;
    tick();
    chk("eof_done", bus.done === 1'b1);
    chk("eof_drained", bus.m_axis_tvalid === 1'b0);
    chk("eof_count_before", bus.result_count === 4'd3);
    tick();
    chk("eof_done_once", bus.done === 1'b0);
    chk("eof_count_clr", bus.result_count === 4'd0);
    chk("eof_ovf_clr", bus.overflow === 1'b0);
    chk("eof_no_lane6", bus.m_axis_tvalid === 1'b0);
    bus.lane_match = 8'h20;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("eof_pos_clr", bus.m_axis_tdata === 8'h05);
    chk("eof_new_count", bus.result_count === 4'd1);
    tick();

    // Soft clear with three results pending
    bus.lane_match = 8'h0F;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("sc_beat", bus.m_axis_tvalid === 1'b1);
    soft_clear();
    chk("sc_tvalid", bus.m_axis_tvalid === 1'b0);
    chk("sc_tdata", bus.m_axis_tdata === 8'h00);
    chk("sc_count", bus.result_count === 4'd0);
    chk("sc_overflow", bus.overflow === 1'b0);
    repeat (2) tick();
    chk("sc_no_beats", bus.m_axis_tvalid === 1'b0);

    // Hard reset while in DRAIN
    bus.m_axis_tready = 1'b0;
    bus.lane_match = 8'h03;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tuser = 1'b1;
    tick();
    bus.lane_match = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser = 1'b0;
    tick();
    chk("rd_held", bus.m_axis_tvalid === 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.m_axis_tready = 1'b1;
    chk("rd_tvalid", bus.m_axis_tvalid === 1'b0);
    chk("rd_count", bus.result_count === 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_no_done", bus.done === 1'b0);
      chk("rd_no_beat", bus.m_axis_tvalid === 1'b0);
    end
    bus.lane_match = 8'h80;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("rd_run_beat", bus.m_axis_tdata === 8'h07);
    chk("rd_run_valid", bus.m_axis_tvalid === 1'b1);
    tick();

    // Masked lane 0 never produces a beat
    bus.result_mask = 8'hFE;
    bus.lane_match = 8'h01;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("mask_none1", bus.m_axis_tvalid === 1'b0);
    tick();
    chk("mask_none2", bus.m_axis_tvalid === 1'b0);
    bus.lane_match = 8'h03;
    tick();
    bus.lane_match = 8'h00;
    tick();
    chk("mask_lane1", bus.m_axis_tdata === 8'h01);
    chk("mask_lane1_valid", bus.m_axis_tvalid === 1'b1);
    tick();
    chk("mask_only_one", bus.m_axis_tvalid === 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
